// File: rtl/mem_tp_pkg.sv
// Shared definitions for the simple-dual-port memory arbiter.
// Holds the derived-width helpers and the read-tag record used by the response pipeline.
// No logic lives here; everything is elaborated at compile time.
package mem_tp_pkg;

  // Widest requester id ever needed (NUM_REQ <= 8).
  localparam int MAX_ID_W = 3;

  // Requester index width; never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One write-enable bit per data byte, rounding a partial byte up.
  function automatic int be_width(input int dw);
    return (dw + 7) / 8;
  endfunction

  // One slot of the read-tag pipeline: which requester owns the data in flight.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mem_tp_arb_if.sv
// Requester-side bundle of the memory arbiter: write/read requests and read responses.
// master = requester side, slave = arbiter side.
// Handshake is valid/ready per requester; responses carry no backpressure.
interface mem_tp_arb_if import mem_tp_pkg::*; #(
  parameter int NUM_REQ       = 2,
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14
);
  localparam int BE_W = be_width(MEM_DATAWIDTH);

  logic [NUM_REQ-1:0]               wr_valid;
  logic [NUM_REQ-1:0]               wr_ready;
  logic [NUM_REQ*BE_W-1:0]          wr_be;
  logic [NUM_REQ*MEM_ADDRWIDTH-1:0] wr_addr;
  logic [NUM_REQ*MEM_DATAWIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]               rd_valid;
  logic [NUM_REQ-1:0]               rd_ready;
  logic [NUM_REQ*MEM_ADDRWIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [MEM_DATAWIDTH-1:0]         rsp_data;

  modport master (
    output wr_valid, wr_be, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_be, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Grant is combinational in the request cycle; the pointer moves on the next edge.
// The caller decides whether a grant really happened through advance (pointer holds otherwise).
module rr_arbiter import mem_tp_pkg::*; #(
  parameter  int N    = 2,
  localparam int ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   cand;
  logic            found;

  // Scan requests circularly starting at the pointer; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N)) cand = cand - (ID_W+1)'(N);
      if (!found && req[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  // Pointer lands just past the winner; wrap is an explicit compare so N need not be 2^k.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_tp_arb.sv
// Shares a simple-dual-port memory's write port A and read port B among NUM_REQ requesters.
// Grants are same-cycle; read data returns MEM_LATENCY cycles after accept, tagged to its requester.
// A read colliding with the granted write address stalls one cycle; responses cannot be backpressured.
module mem_tp_arb import mem_tp_pkg::*; #(
  parameter  int NUM_REQ       = 2,
  parameter  int MEM_DATAWIDTH = 128,
  parameter  int MEM_ADDRWIDTH = 14,
  parameter  int MEM_LATENCY   = 1,
  localparam int ID_W          = id_width(NUM_REQ),
  localparam int BE_W          = be_width(MEM_DATAWIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_tp_arb_if.slave              host,
  output logic                     mem_ena,
  output logic [BE_W-1:0]          mem_wea,
  output logic [MEM_ADDRWIDTH-1:0] mem_addra,
  output logic [MEM_DATAWIDTH-1:0] mem_dina,
  output logic                     mem_enb,
  output logic [MEM_ADDRWIDTH-1:0] mem_addrb,
  input  logic [MEM_DATAWIDTH-1:0] mem_doutb
);

  logic [NUM_REQ-1:0]       wr_gnt, rd_gnt;
  logic [ID_W-1:0]          wr_idx, rd_idx;
  logic                     wr_any, rd_any, collision, rd_issue, tag_busy;
  logic [MEM_ADDRWIDTH-1:0] wr_addr_sel, rd_addr_sel;
  tag_t                     tag_q [MEM_LATENCY];
  tag_t                     tag_out;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (host.wr_valid),
    .advance (wr_any),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  // A stalled read must not move the read pointer, so it retries first next cycle.
  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (host.rd_valid),
    .advance (rd_issue),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  // Steer the winners onto the memory ports; hold the read back on a same-address write.
  always_comb begin
    wr_any      = |wr_gnt;
    rd_any      = |rd_gnt;
    wr_addr_sel = host.wr_addr[int'(wr_idx)*MEM_ADDRWIDTH +: MEM_ADDRWIDTH];
    rd_addr_sel = host.rd_addr[int'(rd_idx)*MEM_ADDRWIDTH +: MEM_ADDRWIDTH];
    collision   = wr_any && rd_any && (wr_addr_sel == rd_addr_sel);
    rd_issue    = rd_any && !collision && !reset;

    host.wr_ready = reset ? '0 : wr_gnt;
    host.rd_ready = rd_issue ? rd_gnt : '0;

    mem_ena   = wr_any && !reset;
    mem_wea   = mem_ena ? host.wr_be[int'(wr_idx)*BE_W +: BE_W] : '0;
    mem_addra = wr_addr_sel;
    mem_dina  = host.wr_data[int'(wr_idx)*MEM_DATAWIDTH +: MEM_DATAWIDTH];
    mem_addrb = rd_addr_sel;
  end

  // Keep port B enabled while any read is in flight so a registered memory output keeps shifting.
  always_comb begin
    tag_busy = 1'b0;
    for (int s = 0; s < MEM_LATENCY; s++) tag_busy = tag_busy | tag_q[s].valid;
    mem_enb = !reset && (rd_issue || tag_busy);

    tag_out        = tag_q[MEM_LATENCY-1];
    host.rsp_valid = (tag_out.valid && !reset) ? (NUM_REQ'(1) << tag_out.id) : '0;
    host.rsp_data  = mem_doutb;
  end

  // Tag pipeline mirrors the memory read latency; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MEM_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].valid <= rd_issue;
      tag_q[0].id    <= MAX_ID_W'(rd_idx);
      for (int s = 1; s < MEM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

endmodule

// File: tb/tb_mem_tp_arb.sv
// Bench for mem_tp_arb: instance A (2 requesters, latency 1) and B (4 requesters, latency 2),
// each in front of a behavioural byte-enabled memory. Expected read responses are queued when
// the read is accepted and compared (requester, data, cycle) when rsp_valid appears.
module tb_mem_tp_arb;
  import mem_tp_pkg::*;

  localparam int A_N = 2, A_DW = 128, A_AW = 14, A_BE = 16;
  localparam int B_N = 4, B_DW = 32,  B_AW = 8,  B_BE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct { int id; logic [127:0] data; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cnt [B_N];

  localparam logic [127:0] DA = {8{16'hAAA0}};
  localparam logic [127:0] DB = {8{16'hBBB1}};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  mem_tp_arb_if #(.NUM_REQ(A_N), .MEM_DATAWIDTH(A_DW), .MEM_ADDRWIDTH(A_AW)) ia ();
  logic            a_ena, a_enb;
  logic [A_BE-1:0] a_wea;
  logic [A_AW-1:0] a_addra, a_addrb;
  logic [A_DW-1:0] a_dina, a_doutb, a_q1, a_w;
  logic [A_DW-1:0] mem_a [256];

  mem_tp_arb #(.NUM_REQ(A_N), .MEM_DATAWIDTH(A_DW), .MEM_ADDRWIDTH(A_AW), .MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .host(ia),
    .mem_ena(a_ena), .mem_wea(a_wea), .mem_addra(a_addra), .mem_dina(a_dina),
    .mem_enb(a_enb), .mem_addrb(a_addrb), .mem_doutb(a_doutb)
  );

  always @(posedge clk) begin
    if (a_ena) begin
      a_w = mem_a[a_addra[7:0]];
      for (int b = 0; b < A_BE; b++) if (a_wea[b]) a_w[b*8 +: 8] = a_dina[b*8 +: 8];
      mem_a[a_addra[7:0]] <= a_w;
    end
    if (a_enb) a_q1 <= mem_a[a_addrb[7:0]];
  end
  assign a_doutb = a_q1;

  // ---------------- instance B ----------------
  mem_tp_arb_if #(.NUM_REQ(B_N), .MEM_DATAWIDTH(B_DW), .MEM_ADDRWIDTH(B_AW)) ib ();
  logic            b_ena, b_enb;
  logic [B_BE-1:0] b_wea;
  logic [B_AW-1:0] b_addra, b_addrb;
  logic [B_DW-1:0] b_dina, b_doutb, b_q1, b_q2, b_w;
  logic [B_DW-1:0] mem_b [256];

  mem_tp_arb #(.NUM_REQ(B_N), .MEM_DATAWIDTH(B_DW), .MEM_ADDRWIDTH(B_AW), .MEM_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .host(ib),
    .mem_ena(b_ena), .mem_wea(b_wea), .mem_addra(b_addra), .mem_dina(b_dina),
    .mem_enb(b_enb), .mem_addrb(b_addrb), .mem_doutb(b_doutb)
  );

  always @(posedge clk) begin
    if (b_ena) begin
      b_w = mem_b[b_addra];
      for (int b = 0; b < B_BE; b++) if (b_wea[b]) b_w[b*8 +: 8] = b_dina[b*8 +: 8];
      mem_b[b_addra] <= b_w;
    end
    if (b_enb) begin
      b_q1 <= mem_b[b_addrb];
      b_q2 <= b_q1;
    end
  end
  assign b_doutb = b_q2;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bdat(input int k);
    return 128'(32'hA0A0_0000 + 32'(k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    ia.wr_valid = '0;
    ia.rd_valid = '0;
  endtask

  task automatic b_idle();
    ib.wr_valid = '0;
    ib.rd_valid = '0;
  endtask

  task automatic a_wr(input int i, input logic [A_AW-1:0] addr, input logic [A_DW-1:0] d,
                      input logic [A_BE-1:0] be);
    ia.wr_valid[i]              = 1'b1;
    ia.wr_addr[i*A_AW +: A_AW]  = addr;
    ia.wr_data[i*A_DW +: A_DW]  = d;
    ia.wr_be[i*A_BE +: A_BE]    = be;
  endtask

  task automatic a_rd(input int i, input logic [A_AW-1:0] addr);
    ia.rd_valid[i]             = 1'b1;
    ia.rd_addr[i*A_AW +: A_AW] = addr;
  endtask

  task automatic b_wr(input int i, input logic [B_AW-1:0] addr, input logic [B_DW-1:0] d);
    ib.wr_valid[i]             = 1'b1;
    ib.wr_addr[i*B_AW +: B_AW] = addr;
    ib.wr_data[i*B_DW +: B_DW] = d;
    ib.wr_be[i*B_BE +: B_BE]   = '1;
  endtask

  task automatic b_rd(input int i, input logic [B_AW-1:0] addr);
    ib.rd_valid[i]             = 1'b1;
    ib.rd_addr[i*B_AW +: B_AW] = addr;
  endtask

  // Response monitors: every rsp_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ia.rsp_valid !== '0) begin
      if (qa.size() == 0) begin
        chk("a_rsp_unexpected", 128'(ia.rsp_valid), 128'(0));
      end else begin
        ea = qa.pop_front();
        chk("a_rsp_owner", 128'(ia.rsp_valid), 128'(1) << ea.id);
        chk("a_rsp_data", ia.rsp_data, ea.data);
        chk("a_rsp_cycle", 128'(cyc), 128'(ea.due));
      end
    end
  end

  always @(negedge clk) begin
    if (ib.rsp_valid !== '0) begin
      if (qb.size() == 0) begin
        chk("b_rsp_unexpected", 128'(ib.rsp_valid), 128'(0));
      end else begin
        eb = qb.pop_front();
        chk("b_rsp_owner", 128'(ib.rsp_valid), 128'(1) << eb.id);
        chk("b_rsp_data", 128'(ib.rsp_data), eb.data);
        chk("b_rsp_cycle", 128'(cyc), 128'(eb.due));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.wr_be = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_addr = '0;
    ib.wr_be = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_addr = '0;
    a_idle();
    b_idle();

    // Requests present during reset must see nothing granted or enabled.
    a_wr(0, 14'h1, '1, '1);
    a_rd(1, 14'h2);
    b_rd(2, 8'h0);
    @(negedge clk);
    chk("a_rst_wr_ready", 128'(ia.wr_ready), 128'(0));
    chk("a_rst_rd_ready", 128'(ia.rd_ready), 128'(0));
    chk("a_rst_mem_ena", 128'(a_ena), 128'(0));
    chk("a_rst_mem_wea", 128'(a_wea), 128'(0));
    chk("a_rst_mem_enb", 128'(a_enb), 128'(0));
    chk("a_rst_rsp_valid", 128'(ia.rsp_valid), 128'(0));
    chk("b_rst_rd_ready", 128'(ib.rd_ready), 128'(0));
    chk("b_rst_mem_enb", 128'(b_enb), 128'(0));
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    a_idle();
    b_idle();

    // Write contention on A: grants alternate 0,1,0,1 with full byte enables.
    a_wr(0, 14'h10, DA, '1);
    a_wr(1, 14'h20, DB, '1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("a_wr_rr", 128'(ia.wr_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      chk("a_wr_wea", 128'(a_wea), 128'(16'hFFFF));
      chk("a_wr_addra", 128'(a_addra), (k % 2 == 0) ? 128'(14'h10) : 128'(14'h20));
      tick();
    end
    a_idle();

    // Read both back; each answer lands one cycle after accept at its owner.
    a_rd(0, 14'h10);
    a_rd(1, 14'h20);
    @(negedge clk);
    chk("a_rd_rr0", 128'(ia.rd_ready), 128'(2'b01));
    qa.push_back('{id: 0, data: DA, due: cyc + 1});
    tick();
    @(negedge clk);
    chk("a_rd_rr1", 128'(ia.rd_ready), 128'(2'b10));
    qa.push_back('{id: 1, data: DB, due: cyc + 1});
    tick();
    a_idle();

    // Same-address write and read: read stalls one cycle and then sees the new data.
    a_wr(0, 14'h3, 128'h55, '1);
    a_rd(1, 14'h3);
    @(negedge clk);
    chk("a_coll_wr_ready", 128'(ia.wr_ready), 128'(2'b01));
    chk("a_coll_rd_stall", 128'(ia.rd_ready), 128'(2'b00));
    tick();
    ia.wr_valid = '0;
    @(negedge clk);
    chk("a_coll_rd_retry", 128'(ia.rd_ready), 128'(2'b10));
    qa.push_back('{id: 1, data: 128'h55, due: cyc + 1});
    tick();
    a_idle();

    // Partial write: only byte 0 of an all-ones word changes. Lone requester wins every cycle.
    a_wr(0, 14'h7, '1, '1);
    @(negedge clk);
    chk("a_pw_full_ready", 128'(ia.wr_ready), 128'(2'b01));
    tick();
    a_wr(0, 14'h7, {16{8'h5A}}, 16'h0001);
    @(negedge clk);
    chk("a_pw_part_ready", 128'(ia.wr_ready), 128'(2'b01));
    chk("a_pw_part_wea", 128'(a_wea), 128'(16'h0001));
    tick();
    a_idle();
    a_rd(0, 14'h7);
    @(negedge clk);
    chk("a_pw_rd_ready", 128'(ia.rd_ready), 128'(2'b01));
    qa.push_back('{id: 0, data: {{120{1'b1}}, 8'h5A}, due: cyc + 1});
    tick();
    a_idle();
    tick();

    // B preload: addresses 0..3 through requester 0.
    for (int k = 0; k < 4; k++) begin
      b_wr(0, 8'(k), 32'hA0A0_0000 + 32'(k));
      @(negedge clk);
      chk("b_pre_wr_ready", 128'(ib.wr_ready), 128'(4'b0001));
      tick();
    end
    b_idle();

    // Latency 2: requesters 3,2,1,0 read addresses 0..3 back to back.
    for (int k = 0; k < 4; k++) begin
      b_idle();
      b_rd(3 - k, 8'(k));
      @(negedge clk);
      chk("b_lat_rd_ready", 128'(ib.rd_ready), 128'(4'b0001 << (3 - k)));
      qa.size();
      qb.push_back('{id: 3 - k, data: bdat(k), due: cyc + 2});
      tick();
    end
    b_idle();
    repeat (4) tick();

    // Two reads in flight when reset hits: neither may answer.
    b_rd(1, 8'h1);
    b_rd(2, 8'h2);
    @(negedge clk);
    chk("b_inflight_rr0", 128'(ib.rd_ready), 128'(4'b0010));
    tick();
    @(negedge clk);
    chk("b_inflight_rr1", 128'(ib.rd_ready), 128'(4'b0100));
    tick();
    b_idle();
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_midrst_rsp_valid", 128'(ib.rsp_valid), 128'(0));
    chk("b_midrst_mem_enb", 128'(b_enb), 128'(0));
    tick();
    rst_b = 1'b0;

    // Fairness after reset: all four read for 8 cycles, order 0,1,2,3,0,1,2,3.
    for (int i = 0; i < B_N; i++) begin
      b_rd(i, 8'(i));
      b_wr(i, 8'(8'h80 + i), 32'h0BAD_0000 + 32'(i));
      cnt[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_fair_rd_ready", 128'(ib.rd_ready), 128'(4'b0001 << (k % 4)));
      if (k == 0) chk("b_postrst_wr_ready", 128'(ib.wr_ready), 128'(4'b0001));
      for (int i = 0; i < B_N; i++) cnt[i] += int'(ib.rd_ready[i]);
      qb.push_back('{id: k % 4, data: bdat(k % 4), due: cyc + 2});
      tick();
      ib.wr_valid = '0;
    end
    b_idle();
    for (int i = 0; i < B_N; i++) chk("b_fair_count", 128'(cnt[i]), 128'(2));

    // Drain: every queued response must have arrived within the budget.
    repeat (6) tick();
    chk("a_queue_drained", 128'(qa.size()), 128'(0));
    chk("b_queue_drained", 128'(qb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_tp_arb.md
Name: mem_tp_arb

Overview:
- Multi-requester arbiter and sequencer in front of the simple-dual-port memory wrapper (mem_tp_wrap): write port A, read port B.
- Shares port A among NUM_REQ write requesters and port B among NUM_REQ read requesters. Each port has an independent round-robin arbiter.
- Tracks in-flight reads through the memory read latency and routes doutb back to the issuing requester.
- Blocks same-cycle read/write collisions on the same address.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MEM_DATAWIDTH, 128, data width, identical to the memory.
- MEM_ADDRWIDTH, 14, address width, identical to the memory.
- MEM_LATENCY, 1, memory read latency in cycles from enb to valid doutb (1..2).
- Derived, not overridable: ID_W = max(1, clog2(NUM_REQ)); BE_W = (MEM_DATAWIDTH+7)/8.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- wr_valid  in  NUM_REQ  per-requester write request.
- wr_ready  out  NUM_REQ  write accepted this cycle.
- wr_be  in  NUM_REQ*BE_W  byte enables, flattened, requester i at slice i.
- wr_addr  in  NUM_REQ*MEM_ADDRWIDTH  write addresses.
- wr_data  in  NUM_REQ*MEM_DATAWIDTH  write data.
- rd_valid  in  NUM_REQ  per-requester read request.
- rd_ready  out  NUM_REQ  read accepted this cycle.
- rd_addr  in  NUM_REQ*MEM_ADDRWIDTH  read addresses.
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe to the owning requester.
- rsp_data  out  MEM_DATAWIDTH  read data, shared by all requesters.
- mem_ena  out  1  to memory ena.
- mem_wea  out  BE_W  to memory wea.
- mem_addra  out  MEM_ADDRWIDTH  to memory addra.
- mem_dina  out  MEM_DATAWIDTH  to memory dina.
- mem_enb  out  1  to memory enb.
- mem_addrb  out  MEM_ADDRWIDTH  to memory addrb.
- mem_doutb  in  MEM_DATAWIDTH  from memory doutb.

Behaviour:
- Reset (synchronous, active-high):
  - Write and read RR pointers go to 0.
  - Tag pipeline is cleared.
  - While reset is high, all ready, rsp_valid, mem_ena, mem_wea and mem_enb are 0.
- Write arbitration (combinational, same cycle):
  - Scan wr_valid starting at the write pointer; the first set bit is the winner g_w.
  - wr_ready[g_w] = 1 (one-hot); all other wr_ready bits are 0.
  - mem_ena = 1; mem_wea, mem_addra and mem_dina take g_w's slices.
  - With no valid request, mem_ena = 0 and mem_wea = 0.
  - The transfer completes in the cycle valid & ready. The write is complete in memory at the next clock edge; no response is returned.
- Read arbitration (same scheme, own pointer):
  - The winner g_r gets rd_ready[g_r] = 1; mem_addrb takes g_r's address.
- Pointer update:
  - After a grant, the pointer moves to (granted index + 1) mod NUM_REQ.
  - With no grant, the pointer holds.
  - Requesters do not need to keep valid high until granted. A request dropped before its grant is not served.
- Collision rule:
  - If a write grant and the read candidate g_r target the same address in the same cycle, the read is stalled: rd_ready = 0 and the read pointer holds.
  - The write proceeds. The read wins the next cycle and returns the new data.
  - Addresses are compared in full; byte enables are ignored.
- mem_enb:
  - mem_enb = read issue OR any valid entry in the tag pipeline, so that a 2-stage memory output register keeps advancing.
  - mem_addrb is don't-care on non-issue cycles.
- Tag pipeline:
  - MEM_LATENCY stages of {valid, id[ID_W]}. Stage 0 loads {issue, g_r} each cycle.
  - At the output stage, rsp_valid = onehot(id) when the stage is valid, otherwise 0.
  - rsp_data = mem_doutb, passed through combinationally.
  - Read latency from accept to rsp_valid is exactly MEM_LATENCY cycles.
  - Back-to-back reads give one response per cycle, in issue order.
  - There is no response backpressure; requesters must always sink rsp_valid.
- Throughput: one write and one read per cycle, except on a collision stall.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid, and pointers return to 0.
- Single requester (NUM_REQ sets only one valid bit): that requester is granted every cycle.
- Widths: pointer and id are ID_W bits. Pointer wrap is a compare at NUM_REQ-1, not a power-of-two overflow.

Decomposition:
- Shared package mem_tp_pkg holds:
  - the clog2-based ID_W function;
  - the BE_W derivation;
  - the tag struct/typedef {valid, id}.
- One sub-module, rr_arbiter (parameters N; ports clk, reset, req[N], advance, gnt[N], gnt_idx).
  - Instantiated twice, once for writes and once for reads.
  - Read-side advance = grant & ~collision.
- The tag pipeline and the collision compare stay in the top module.

Test Plan:
- Contention on both ports: NUM_REQ=2, MEM_LATENCY=1. Both requesters hold wr_valid for 4 cycles, addresses 0x10/0x20, data A/B. Required: grants alternate 0,1,0,1; mem_wea is all ones on each write. Reads back return A/B with rsp_valid one cycle after accept, to the correct requester.
- Collision: same cycle, req0 writes 0x55 to address 0x3 and req1 reads address 0x3. Required: rd_ready[1]=0 in that cycle and 1 in the next; rsp_data = 0x55 one cycle later.
- Output-register latency: MEM_LATENCY=2, NUM_REQ=4. Four back-to-back reads of pre-loaded addresses 0..3 from requesters 3,2,1,0. Required: rsp_valid one-hot 1000,0100,0010,0001 on cycles +2..+5 with matching data.
- Fairness: NUM_REQ=4, all reads valid for 8 cycles. Required: each requester is granted exactly twice, order 0,1,2,3,0,1,2,3.
- Reset mid-operation: reset asserted for 1 cycle while 2 reads are in flight. Required: no rsp_valid afterwards; after deassert, the first grant goes to requester 0.
- Partial write: wr_be=0x0001 to address 0x7 after a full write of 0xFF..FF. Required: readback shows only byte 0 changed.
